// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the byte-serial data memory
// responder.
//   dmem_state_e     : responder FSM states (IDLE / XFER / DONE)
//   SIZE_* / RW_*    : encodings of the m_size / m_rw request fields
//   DMEM_DEPTH_DEF   : default data store size in bytes
//   word_lane()      : big-endian byte lane select (lane 0 = bits [31:24])
package dmem_pkg;

   localparam int DMEM_DEPTH_DEF = 256;

   localparam logic SIZE_BYTE = 1'b1;
   localparam logic SIZE_WORD = 1'b0;
   localparam logic RW_READ   = 1'b0;
   localparam logic RW_WRITE  = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_DONE = 2'd2
   } dmem_state_e;

   function automatic logic [7:0] word_lane(input logic [31:0] w, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// dmem_byte_array: DEPTH x 8 data store.
//   clk   : write clock
//   we    : write enable, byte written on the rising edge
//   addr  : byte address shared by read and write port
//   wdata : byte to write
//   rdata : combinational read of mem[addr]
// The array has no reset; contents survive a responder reset.
module dmem_byte_array #(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: byte-serial data memory responder for MEM-stage
// requests. One byte moves per clock; words are big-endian (lowest address
// in DataOut[31:24]).
//   CLK, CLR          : clock, asynchronous active-low reset
//   m_enable          : request valid, only sampled in IDLE
//   m_rw, m_size      : 1 = store / 0 = load, 1 = byte / 0 = word
//   Address, DataIn   : byte address (low ADDR_W bits used), store data
//   DataOut           : load result, held until the next load completes
//   busy, done        : state != IDLE, one-cycle completion pulse
//   align_err         : one-cycle pulse with done on a misaligned word request
// Optional feature macro: DMEM_ALIGN_ERR_EN. When defined, misaligned word
// requests skip the transfer and report align_err; when undefined, word
// addresses are forced to a 4-byte boundary and align_err is tied low.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | waiting for m_enable; request fields latched on accept
// ST_XFER | one byte per edge at base+cnt, until cnt == last
// ST_DONE | done (and align_err) high for this one cycle
module data_mem_responder
   import dmem_pkg::*;
#(
   parameter int MEM_DEPTH = DMEM_DEPTH_DEF,
   parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
   input  logic        CLK,
   input  logic        CLR,
   input  logic        m_enable,
   input  logic        m_rw,
   input  logic        m_size,
   input  logic [31:0] Address,
   input  logic [31:0] DataIn,
   output logic [31:0] DataOut,
   output logic        busy,
   output logic        done,
   output logic        align_err
);

   dmem_state_e       state_q;
   logic [1:0]        cnt_q;
   logic [1:0]        last_q;
   logic [ADDR_W-1:0] base_q;
   logic [31:0]       wdata_q;
   logic              rw_q;
   logic              size_q;
   logic [23:0]       shift_q;
   logic [31:0]       dout_q;
   logic              done_q;
   logic              aerr_q;

   logic [ADDR_W-1:0] req_addr;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_rdata;
   logic [7:0]        mem_wdata;
   logic              mem_we;
   logic              misalign;

   // Address bits above ADDR_W are deliberately ignored (address wrap).
   logic unused_addr_hi;
   assign unused_addr_hi = ^Address[31:ADDR_W];

`ifdef DMEM_ALIGN_ERR_EN
   assign misalign = (m_size == SIZE_WORD) && (Address[1:0] != 2'b00);
   assign req_addr = Address[ADDR_W-1:0];
`else
   assign misalign = 1'b0;
   assign req_addr = (m_size == SIZE_WORD) ? {Address[ADDR_W-1:2], 2'b00}
                                           : Address[ADDR_W-1:0];
`endif

   // In IDLE the read port looks at the incoming request so a misaligned
   // word load can return its single byte on the accepting edge.
   assign mem_addr  = (state_q == ST_IDLE) ? req_addr : (base_q + ADDR_W'(cnt_q));
   assign mem_we    = (state_q == ST_XFER) && (rw_q == RW_WRITE);
   assign mem_wdata = (size_q == SIZE_BYTE) ? wdata_q[7:0] : word_lane(wdata_q, cnt_q);

   dmem_byte_array #(
      .DEPTH (MEM_DEPTH),
      .AW    (ADDR_W)
   ) u_array (
      .clk   (CLK),
      .we    (mem_we),
      .addr  (mem_addr),
      .wdata (mem_wdata),
      .rdata (mem_rdata)
   );

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         state_q <= ST_IDLE;
         cnt_q   <= 2'd0;
         last_q  <= 2'd0;
         base_q  <= '0;
         wdata_q <= 32'd0;
         rw_q    <= RW_READ;
         size_q  <= SIZE_WORD;
         shift_q <= 24'd0;
         dout_q  <= 32'd0;
         done_q  <= 1'b0;
         aerr_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         aerr_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (m_enable) begin
                  base_q  <= req_addr;
                  wdata_q <= DataIn;
                  rw_q    <= m_rw;
                  size_q  <= m_size;
                  cnt_q   <= 2'd0;
                  last_q  <= (m_size == SIZE_BYTE) ? 2'd0 : 2'd3;
                  if (misalign) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                     aerr_q  <= 1'b1;
                     if (m_rw == RW_READ) begin
                        dout_q <= {24'd0, mem_rdata};
                     end
                  end else begin
                     state_q <= ST_XFER;
                  end
               end
            end
            ST_XFER: begin
               if (rw_q == RW_READ) begin
                  shift_q <= {shift_q[15:0], mem_rdata};
               end
               if (cnt_q == last_q) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                  // Final byte comes straight from the array so DataOut is
                  // valid in the same cycle as done.
                  if (rw_q == RW_READ) begin
                     dout_q <= (size_q == SIZE_BYTE) ? {24'd0, mem_rdata}
                                                     : {shift_q, mem_rdata};
                  end
               end else begin
                  cnt_q <= cnt_q + 2'd1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign DataOut   = dout_q;
   assign align_err = aerr_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

   logic        CLK;
   logic        CLR;
   logic        m_enable;
   logic        m_rw;
   logic        m_size;
   logic [31:0] Address;
   logic [31:0] DataIn;
   logic [31:0] DataOut;
   logic        busy;
   logic        done;
   logic        align_err;

   int n_cmp = 0;
   int n_mis = 0;

   logic [32:0] exp_q[$];   // {align_err, DataOut}
   logic [31:0] last_dout;

   data_mem_responder dut (
      .CLK       (CLK),
      .CLR       (CLR),
      .m_enable  (m_enable),
      .m_rw      (m_rw),
      .m_size    (m_size),
      .Address   (Address),
      .DataIn    (DataIn),
      .DataOut   (DataOut),
      .busy      (busy),
      .done      (done),
      .align_err (align_err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_mis++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
      end
   endtask

   // Monitor: every done pulse is matched against the oldest expectation.
   initial begin
      logic [32:0] e;
      forever begin
         @(negedge CLK);
         if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_mis++;
               $display("FAIL unexpected_done: got done=1 expected no completion at %0t", $time);
            end else begin
               e = exp_q.pop_front();
               chk("sb_dataout", DataOut, e[31:0]);
               chk("sb_align_err", {31'd0, align_err}, {31'd0, e[32]});
            end
         end
      end
   end

   // Issue one request; must be called right after a falling edge.
   task automatic req(input logic rw, input logic size, input logic [31:0] addr,
                      input logic [31:0] data, input logic [31:0] load_exp,
                      input logic exp_aerr, input int exp_lat);
      int  n;
      bit  got;
      logic [31:0] e;
      e = (rw == 1'b1) ? last_dout : load_exp;
      last_dout = e;
      m_enable = 1'b1;
      m_rw     = rw;
      m_size   = size;
      Address  = addr;
      DataIn   = data;
      exp_q.push_back({exp_aerr, e});
      @(posedge CLK);
      #1 m_enable = 1'b0;
      n   = 0;
      got = 0;
      while (!got && n < 20) begin
         @(negedge CLK);
         n++;
         if (n == 1) chk("busy_after_accept", {31'd0, busy}, 32'd1);
         if (done === 1'b1) got = 1;
      end
      if (!got) begin
         n_cmp++;
         n_mis++;
         $display("FAIL done_timeout: got no done after %0d cycles expected latency %0d", n, exp_lat);
      end else begin
         chk("latency", 32'(n - 1), 32'(exp_lat));
      end
      @(negedge CLK);
      chk("busy_after_done", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      logic [7:0] exp_b [4];
      int  n;
      bit  got;
      exp_b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      last_dout = 32'd0;
      CLR      = 1'b0;
      m_enable = 1'b0;
      m_rw     = 1'b0;
      m_size   = 1'b0;
      Address  = 32'd0;
      DataIn   = 32'd0;
      repeat (3) @(negedge CLK);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_dataout", DataOut, 32'd0);
      chk("rst_align_err", {31'd0, align_err}, 32'd0);
      CLR = 1'b1;
      @(negedge CLK);

      // word store / load, byte lane order
      req(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, 4);
      req(1'b0, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, 4);
      for (int i = 0; i < 4; i++) begin
         req(1'b0, 1'b1, 32'h10 + 32'(i), 32'd0, {24'd0, exp_b[i]}, 1'b0, 1);
      end

      // byte store into a word
      req(1'b1, 1'b1, 32'h13, 32'h000000A5, 32'd0, 1'b0, 1);
      req(1'b0, 1'b0, 32'h10, 32'd0, 32'hDEADBEA5, 1'b0, 4);
      req(1'b0, 1'b1, 32'h13, 32'd0, 32'h000000A5, 1'b0, 1);

      // misaligned word accesses
`ifdef DMEM_ALIGN_ERR_EN
      req(1'b0, 1'b0, 32'h11, 32'd0, 32'h000000AD, 1'b1, 0);
      req(1'b1, 1'b0, 32'h11, 32'hFFFFFFFF, 32'd0, 1'b1, 0);
      req(1'b0, 1'b0, 32'h10, 32'd0, 32'hDEADBEA5, 1'b0, 4);
`else
      req(1'b0, 1'b0, 32'h11, 32'd0, 32'hDEADBEA5, 1'b0, 4);
      req(1'b1, 1'b0, 32'h32, 32'h01020304, 32'd0, 1'b0, 4);
      req(1'b0, 1'b0, 32'h30, 32'd0, 32'h01020304, 1'b0, 4);
`endif

      // address wrap
      req(1'b1, 1'b0, 32'hFC, 32'hCAFEF00D, 32'd0, 1'b0, 4);
      req(1'b0, 1'b0, 32'h1FC, 32'd0, 32'hCAFEF00D, 1'b0, 4);
      req(1'b1, 1'b1, 32'h100, 32'h0000005A, 32'd0, 1'b0, 1);
      req(1'b0, 1'b1, 32'h0, 32'd0, 32'h0000005A, 1'b0, 1);
      req(1'b0, 1'b1, 32'hFF, 32'd0, 32'h0000000D, 1'b0, 1);

      // m_enable held high through a word store
      m_enable = 1'b1;
      m_rw     = 1'b1;
      m_size   = 1'b0;
      Address  = 32'h40;
      DataIn   = 32'h0BADF00D;
      exp_q.push_back({1'b0, last_dout});
      exp_q.push_back({1'b0, last_dout});
      @(posedge CLK);
      n   = 0;
      got = 0;
      while (!got && n < 20) begin
         @(negedge CLK);
         n++;
         if (done === 1'b1) got = 1;
      end
      chk("hold_first_latency", 32'(n - 1), 32'd4);
      @(negedge CLK);
      chk("hold_idle_gap", {31'd0, busy}, 32'd0);
      @(negedge CLK);
      chk("hold_reaccept", {31'd0, busy}, 32'd1);
      m_enable = 1'b0;
      n   = 0;
      got = 0;
      while (!got && n < 20) begin
         @(negedge CLK);
         n++;
         if (done === 1'b1) got = 1;
      end
      chk("hold_second_latency", 32'(n), 32'd4);
      @(negedge CLK);
      chk("hold_busy_end", {31'd0, busy}, 32'd0);
      req(1'b0, 1'b0, 32'h40, 32'd0, 32'h0BADF00D, 1'b0, 4);

      // reset in the middle of a word store
      req(1'b1, 1'b0, 32'h20, 32'h00000000, 32'd0, 1'b0, 4);
      m_enable = 1'b1;
      m_rw     = 1'b1;
      m_size   = 1'b0;
      Address  = 32'h20;
      DataIn   = 32'h11223344;
      @(posedge CLK);
      #1 m_enable = 1'b0;
      @(posedge CLK);
      @(posedge CLK);
      #1 CLR = 1'b0;
      #1;
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_done", {31'd0, done}, 32'd0);
      chk("midrst_dataout", DataOut, 32'd0);
      last_dout = 32'd0;
      @(negedge CLK);
      CLR = 1'b1;
      @(negedge CLK);
      req(1'b0, 1'b0, 32'h20, 32'd0, 32'h11220000, 1'b0, 4);
      req(1'b0, 1'b1, 32'h22, 32'd0, 32'h00000000, 1'b0, 1);

      repeat (3) @(negedge CLK);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
